// File: rtl/nbank_spfifo.sv
`default_nettype none
// ============================================================================
// Module   : nbank_spfifo (with bank model d1spram)
// Brief    : Stream FIFO over BANKS interleaved single-port banks with a
//            one-entry write stash; one push and one pop per cycle.
//            Optional sticky overflow/underflow flags: NBANK_SPFIFO_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================

module d1spram #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 16,
    parameter int SRAM  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs,
    input  logic                     we,
    input  logic [$clog2(ROWS)-1:0]  addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] r_mem [ROWS];

    always_ff @(posedge clk) begin
        if (cs && we) r_mem[addr] <= wdata;
    end

    generate
        if (SRAM != 0) begin : g_macro
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk) begin
                if (!rst_n)          r_q <= '0;
                else if (cs && !we)  r_q <= r_mem[addr];
            end
            assign rdata = r_q;
        end else begin : g_flop
            // Flop model: latch the read row, mux the array combinationally.
            logic [$clog2(ROWS)-1:0] r_addr;
            always_ff @(posedge clk) begin
                if (!rst_n)          r_addr <= '0;
                else if (cs && !we)  r_addr <= addr;
            end
            assign rdata = r_mem[r_addr];
        end
    endgenerate
endmodule

module nbank_spfifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int BANKS    = 2,
    parameter int SRAM     = 1,
    parameter int AL_FULL  = 2,
    parameter int AL_EMPTY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     al_full,
    output logic                     al_empty,
    output logic                     ack,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int c_aw   = $clog2(DEPTH);
    localparam int c_bw   = $clog2(BANKS);
    localparam int c_rw   = c_aw - c_bw;
    localparam int c_rows = DEPTH / BANKS;
    localparam logic [c_aw:0] c_depth    = (c_aw+1)'(DEPTH);
    localparam logic [c_aw:0] c_af_level = (c_aw+1)'(DEPTH - AL_FULL);
    localparam logic [c_aw:0] c_ae_level = (c_aw+1)'(AL_EMPTY);
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_held = 1'b1;

    logic [c_aw:0]      r_wr_ptr, r_rd_ptr, w_count;
    logic               w_wen, w_ren, w_conflict;
    logic [c_bw-1:0]    w_wbank, w_rbank;
    logic [c_rw-1:0]    w_wrow, w_rrow;

    logic [0:0]         r_st_state;
    logic [WIDTH-1:0]   r_st_data;
    logic [c_rw-1:0]    r_st_row;
    logic [c_bw-1:0]    r_st_bank;

    logic               r_rd_valid;
    logic [c_bw-1:0]    r_rd_bank;

    logic [BANKS-1:0]   w_cs, w_we;
    logic [c_rw-1:0]    w_addr [BANKS];
    logic [WIDTH-1:0]   w_bdin [BANKS];
    logic [WIDTH-1:0]   w_bdout[BANKS];

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign full    = (w_count == c_depth);
    assign empty   = (w_count == '0);
    assign w_wen   = push & ~full & ~rst;
    assign w_ren   = pop & ~empty & ~rst;
    assign w_wbank = r_wr_ptr[c_bw-1:0];
    assign w_rbank = r_rd_ptr[c_bw-1:0];
    assign w_wrow  = r_wr_ptr[c_aw-1:c_bw];
    assign w_rrow  = r_rd_ptr[c_aw-1:c_bw];
    assign w_conflict = w_wen & w_ren & (w_wbank == w_rbank);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_bank  <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + (c_aw+1)'(w_wen);
            r_rd_ptr   <= r_rd_ptr + (c_aw+1)'(w_ren);
            r_rd_valid <= w_ren;
            r_rd_bank  <= w_rbank;
        end
    end

    // A held entry always drains next cycle: the read and write pointers have
    // both moved past its bank, so it can be overwritten by a new conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st_state <= c_st_idle;
            r_st_data  <= '0;
            r_st_row   <= '0;
            r_st_bank  <= '0;
        end else if (w_conflict) begin
            r_st_state <= c_st_held;
            r_st_data  <= wdata;
            r_st_row   <= w_wrow;
            r_st_bank  <= w_wbank;
        end else begin
            r_st_state <= c_st_idle;
        end
    end

    always_comb begin
        for (int k = 0; k < BANKS; k++) begin
            w_cs[k]   = 1'b0;
            w_we[k]   = 1'b0;
            w_addr[k] = '0;
            w_bdin[k] = '0;
            if (w_ren && (w_rbank == c_bw'(k))) begin
                w_cs[k]   = 1'b1;
                w_addr[k] = w_rrow;
            end else if (w_wen && !w_conflict && (w_wbank == c_bw'(k))) begin
                w_cs[k]   = 1'b1;
                w_we[k]   = 1'b1;
                w_addr[k] = w_wrow;
                w_bdin[k] = wdata;
            end else if ((r_st_state == c_st_held) && (r_st_bank == c_bw'(k))) begin
                w_cs[k]   = 1'b1;
                w_we[k]   = 1'b1;
                w_addr[k] = r_st_row;
                w_bdin[k] = r_st_data;
            end
        end
    end

    generate
        for (genvar g = 0; g < BANKS; g++) begin : g_bank
            d1spram #(
                .WIDTH (WIDTH),
                .ROWS  (c_rows),
                .SRAM  (SRAM)
            ) u_bank (
                .clk   (clk),
                .rst_n (~rst),
                .cs    (w_cs[g]),
                .we    (w_we[g]),
                .addr  (w_addr[g]),
                .wdata (w_bdin[g]),
                .rdata (w_bdout[g])
            );
        end

        if (AL_FULL != 0) begin : g_alf_on
            assign al_full = (w_count >= c_af_level);
        end else begin : g_alf_off
            assign al_full = 1'b0;
        end

        if (AL_EMPTY != 0) begin : g_ale_on
            assign al_empty = (w_count <= c_ae_level);
        end else begin : g_ale_off
            assign al_empty = 1'b0;
        end
    endgenerate

    assign rdata = r_rd_valid ? w_bdout[r_rd_bank] : '0;
    assign valid = r_rd_valid;
    assign ack   = w_wen;
    assign count = w_count;

`ifdef NBANK_SPFIFO_ERR_EN
    logic r_overflow, r_underflow;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && full)  r_overflow  <= 1'b1;
            if (pop && empty)  r_underflow <= 1'b1;
        end
    end
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nbank_spfifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbank_spfifo
// Brief    : Directed bench for nbank_spfifo (BANKS=4, DEPTH=32) against a
//            queue-based reference of FIFO behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbank_spfifo;
    localparam int W = 16;
    localparam int D = 32;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           push = 1'b0, pop = 1'b0;
    logic [W-1:0]   wdata = '0;
    logic [W-1:0]   rdata;
    logic           full, empty, al_full, al_empty, ack, valid;
    logic [5:0]     count;
    logic           overflow, underflow;

    always #5 clk = ~clk;

    nbank_spfifo #(
        .WIDTH(W), .DEPTH(D), .BANKS(B), .SRAM(1), .AL_FULL(2), .AL_EMPTY(2)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(wdata),
        .rdata(rdata), .full(full), .empty(empty), .al_full(al_full),
        .al_empty(al_empty), .ack(ack), .valid(valid), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    // Reference: an ordered queue of stored words plus last-pop result.
    logic [W-1:0] q[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_rdata = '0;
    logic         m_ovf = 1'b0, m_udf = 1'b0;
    int           n_chk = 0, n_fail = 0;
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic take_pop, take_push;
        if (rst) begin
            q.delete();
            m_valid = 1'b0; m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            take_pop  = pop && (q.size() > 0);
            take_push = push && (q.size() < D);
            if (push && q.size() == D) m_ovf = 1'b1;
            if (pop && q.size() == 0)  m_udf = 1'b1;
            if (take_pop) begin
                m_rdata = q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_rdata = '0;
                m_valid = 1'b0;
            end
            if (take_push) q.push_back(wdata);
        end
    endtask

    task automatic step(input logic p, input logic o, input logic [W-1:0] d);
        push = p; pop = o; wdata = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            automatic int sz = q.size();
            check("count",    32'(count),    32'(sz));
            check("empty",    32'(empty),    32'(sz == 0));
            check("full",     32'(full),     32'(sz == D));
            check("al_full",  32'(al_full),  32'(sz >= D - 2));
            check("al_empty", 32'(al_empty), 32'(sz <= 2));
            check("ack",      32'(ack),      32'(push && sz < D && !rst));
            check("valid",    32'(valid),    32'(m_valid));
            check("rdata",    32'(rdata),    32'(m_rdata));
`ifdef NBANK_SPFIFO_ERR_EN
            check("overflow",  32'(overflow),  32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_udf));
`else
            check("overflow",  32'(overflow),  32'd0);
            check("underflow", 32'(underflow), 32'd0);
`endif
        end
    end

    initial begin
        step(0, 0, 0);
        step(0, 0, 0);
        chk_en = 1'b1;
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_count",    32'(count),    32'd0);
        check("rst_valid",    32'(valid),    32'd0);
        check("rst_al_empty", 32'(al_empty), 32'd1);
        check("rst_full",     32'(full),     32'd0);
        rst = 1'b0;

        // Fill to full, then one rejected push
        for (int i = 0; i < 32; i++) step(1, 0, W'(i));
        check("fill_count",   32'(count),   32'd32);
        check("fill_full",    32'(full),    32'd1);
        check("fill_al_full", 32'(al_full), 32'd1);
        step(1, 0, 16'hDEAD);
        check("ovf_count", 32'(count), 32'd32);
`ifdef NBANK_SPFIFO_ERR_EN
        check("ovf_flag", 32'(overflow), 32'd1);
`endif

        // Drain in order
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 0);
            if (i == 0) begin
                check("pop0_valid", 32'(valid), 32'd1);
                check("pop0_rdata", 32'(rdata), 32'd0);
            end
        end
        check("pop31_rdata", 32'(rdata), 32'd31);
        check("drain_empty", 32'(empty), 32'd1);
        step(0, 1, 0);
        check("extra_valid", 32'(valid), 32'd0);
        check("extra_rdata", 32'(rdata), 32'd0);
`ifdef NBANK_SPFIFO_ERR_EN
        check("udf_flag", 32'(underflow), 32'd1);
`endif

        // Push at t, pop at t+1
        step(1, 0, 16'hBEEF);
        step(0, 1, 0);
        check("p2p_valid", 32'(valid), 32'd1);
        check("p2p_rdata", 32'(rdata), 32'hBEEF);
        step(0, 0, 0);

        // Streaming at occupancy 1, then at occupancy BANKS (write hits read bank)
        step(1, 0, 16'h1000);
        for (int i = 0; i < 100; i++) step(1, 1, W'(16'h1001 + i));
        check("stream1_count", 32'(count), 32'd1);
        check("stream1_rdata", 32'(rdata), 32'h1063);
        for (int i = 0; i < 3; i++) step(1, 0, W'(16'h2000 + i));
        for (int i = 0; i < 100; i++) step(1, 1, W'(16'h3000 + i));
        check("stream4_count", 32'(count), 32'd4);
        check("stream4_rdata", 32'(rdata), 32'h305F);
        for (int i = 0; i < 4; i++) step(0, 1, 0);

        // Threshold flags
        for (int i = 0; i < 30; i++) begin
            step(1, 0, W'(16'h40 + i));
            if (i == 28) check("alf_at29", 32'(al_full), 32'd0);
        end
        check("alf_at30", 32'(al_full), 32'd1);
        for (int i = 0; i < 28; i++) begin
            step(0, 1, 0);
            if (i == 26) check("ale_at3", 32'(al_empty), 32'd0);
        end
        check("ale_at2",   32'(al_empty), 32'd1);
        check("ale_count", 32'(count),    32'd2);
        step(0, 1, 0);
        step(0, 1, 0);

        // Reset with stash held and a read in flight
        for (int i = 0; i < 4; i++) step(1, 0, W'(16'h50 + i));
        step(1, 1, 16'h60);
        check("pre_rst_valid", 32'(valid), 32'd1);
        check("pre_rst_rdata", 32'(rdata), 32'h50);
        rst = 1'b1;
        step(1, 1, 16'h61);
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_empty", 32'(empty), 32'd1);
        check("rst_mid_count", 32'(count), 32'd0);
        rst = 1'b0;
        step(1, 0, 16'h70);
        step(0, 1, 0);
        check("post_rst_rdata", 32'(rdata), 32'h70);
        step(0, 0, 0);
        check("post_rst_empty", 32'(empty), 32'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
